disk_track_cache: RTL and testbench

- Track-buffer controller between hps_io's SD sector interface and the Disk II track RAM read by apple2_top.
- On a head track change it writes the current track back to the NIB image if the track is dirty. It then loads the new track as 13 consecutive 512-byte sectors.
- Holds the CPU in wait for the whole transfer.
- Adds write support to the disk path, which is currently read-only.

---
 rtl/disk_pkg.sv | 20 ++
 rtl/disk_track_cache_edge_det.sv | 21 ++
 rtl/disk_track_cache.sv | 173 +++++++++++++++++
 tb/tb_disk_track_cache.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disk_pkg.sv
// rtl/disk_pkg.sv - shared constants and state type for the Disk II track cache
package disk_pkg;

  // One NIB track is 13 consecutive 512-byte SD sectors.
  localparam int NIB_SECTORS     = 13;
  localparam int NIB_TRACK_BYTES = NIB_SECTORS * 512;

  // Default track-number width and the "no track loaded" marker at that width.
  localparam int              TRK_W_DEF   = 6;
  localparam logic [TRK_W_DEF-1:0] TRK_INVALID = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB_REQ,
    ST_WB_XFER,
    ST_RD_REQ,
    ST_RD_XFER
  } cache_state_t;

endpackage

// File: rtl/disk_track_cache_edge_det.sv
// rtl/disk_track_cache_edge_det.sv - registered rise/fall detector for sd_ack
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Previous-cycle copy of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/disk_track_cache.sv
// rtl/disk_track_cache.sv - track buffer controller: dirty write-back and track load over the SD sector port
module disk_track_cache
  import disk_pkg::*;
#(
  parameter int SECTORS = NIB_SECTORS,
  parameter int SEC_W   = 4,
  parameter int TRK_W   = TRK_W_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRK_W-1:0]   track,
  input  logic               track_dirty_set,
  input  logic               img_mounted,
  input  logic [63:0]        img_size,
  input  logic               img_readonly,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  output logic [SEC_W+8:0]   ram_addr,
  output logic               ram_we,
  output logic [7:0]         ram_di,
  input  logic [7:0]         ram_do,
  output logic               cpu_wait,
  output logic               busy
);

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECTORS - 1);
  localparam logic [TRK_W-1:0] TRK_NONE = {TRK_W{1'b1}};

  cache_state_t     state;
  logic [SEC_W-1:0] sec;
  logic [TRK_W-1:0] cur_track;
  logic             dirty;
  logic             mount_pend;
  logic             ack_rise;
  logic             ack_fall;
  logic             has_image;

  // First LBA of a track; a constant shift-add, evaluated only at operation start.
  function automatic logic [31:0] track_lba(input logic [TRK_W-1:0] t);
    logic [31:0] acc;
    acc = '0;
    for (int b = 0; b < 31; b++) begin
      if (((SECTORS >> b) & 1) != 0) acc = acc + (32'(t) << b);
    end
    return acc;
  endfunction

  edge_det u_ack_edge (
    .clk  (clk_sys),
    .rst  (reset),
    .d    (sd_ack),
    .rise (ack_rise),
    .fall (ack_fall)
  );

  assign has_image   = (img_size != 64'd0);
  assign ram_addr    = {sec, sd_buff_addr};
  assign ram_di      = sd_buff_dout;
  assign ram_we      = sd_buff_wr && (state == ST_RD_XFER);
  assign sd_buff_din = ram_do;

  // Sector-loop FSM: optional write-back of the old track, then load of the new one.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_lba     <= '0;
      cpu_wait   <= 1'b0;
      busy       <= 1'b0;
      sec        <= '0;
      dirty      <= 1'b0;
      mount_pend <= 1'b0;
      cur_track  <= TRK_NONE;
    end else begin
      // A new image makes any pending write-back meaningless.
      if (img_mounted) begin
        dirty <= 1'b0;
        if (state != ST_IDLE) mount_pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (img_mounted || mount_pend) begin
            cur_track  <= TRK_NONE;
            mount_pend <= 1'b0;
          end else if (track != cur_track) begin
            if (has_image) begin
              cpu_wait <= 1'b1;
              busy     <= 1'b1;
              sec      <= '0;
              if ((dirty || track_dirty_set) && !img_readonly) begin
                sd_lba <= track_lba(cur_track);
                sd_wr  <= 1'b1;
                dirty  <= 1'b0;
                state  <= ST_WB_REQ;
              end else begin
                cur_track <= track;
                sd_lba    <= track_lba(track);
                sd_rd     <= 1'b1;
                state     <= ST_RD_REQ;
              end
            end else begin
              cur_track <= track;
            end
          end else if (track_dirty_set) begin
            dirty <= 1'b1;
          end
        end

        ST_WB_REQ, ST_RD_REQ: begin
          if (ack_rise) begin
            state <= (state == ST_WB_REQ) ? ST_WB_XFER : ST_RD_XFER;
            if (sec == SEC_LAST) begin
              sd_wr <= 1'b0;
              sd_rd <= 1'b0;
            end
          end
        end

        ST_WB_XFER: begin
          if (ack_fall) begin
            sd_lba <= sd_lba + 32'd1;
            if (sec != SEC_LAST) sec <= sec + 1'b1;
            if (mount_pend) begin
              sd_wr    <= 1'b0;
              cpu_wait <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else if (sd_wr) begin
              state <= ST_WB_REQ;
            end else begin
              cur_track <= track;
              sd_lba    <= track_lba(track);
              sec       <= '0;
              sd_rd     <= 1'b1;
              state     <= ST_RD_REQ;
            end
          end
        end

        ST_RD_XFER: begin
          if (ack_fall) begin
            sd_lba <= sd_lba + 32'd1;
            if (sec != SEC_LAST) sec <= sec + 1'b1;
            if (mount_pend) begin
              sd_rd    <= 1'b0;
              cpu_wait <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else if (sd_rd) begin
              state <= ST_RD_REQ;
            end else begin
              dirty    <= 1'b0;
              cpu_wait <= 1'b0;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disk_track_cache.sv
// tb/tb_disk_track_cache.sv - self-checking bench for disk_track_cache with SD and track RAM models
module tb_disk_track_cache;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        track_dirty_set;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  logic        cpu_wait;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference world: image contents, expected track RAM, observed SD operations.
  logic [7:0] img_wr [int];
  int         gen  = 0;
  int         seed = 0;
  logic [7:0] ref_trk [6656];
  int         obs [$];
  int         cw_bad  = 0;
  int         din_bad = 0;
  int         we_cnt  = 0;

  logic [7:0]  mem [8192];
  logic        poke_en = 1'b0;
  logic [12:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  disk_track_cache dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .track_dirty_set(track_dirty_set),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di),
    .ram_do(ram_do), .cpu_wait(cpu_wait), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Track RAM: DUT write port plus a CPU-side poke port, registered read.
  always @(posedge clk_sys) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_di;
      we_cnt <= we_cnt + 1;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
    ram_do <= mem[ram_addr];
  end

  function automatic logic [7:0] img_byte(input int lba, input int i);
    int k;
    k = lba * 512 + i;
    if (img_wr.exists(k)) return img_wr[k];
    return 8'((lba * 37 + i * 11 + gen * 101 + seed) ^ (i >> 3));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // SD card model: serves one sector per request, verifies write-back data.
  initial begin : sd_model
    int lba;
    int wr;
    logic [7:0] sbuf [512];
    logic aborted;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      if (!reset && (sd_rd || sd_wr)) begin
        wr  = int'(sd_wr);
        lba = int'(sd_lba);
        obs.push_back(wr * 65536 + lba);
        repeat ($urandom_range(0, 3)) @(posedge clk_sys);
        #1;
        if (!cpu_wait || !busy) cw_bad++;
        sd_ack = 1'b1;
        aborted = 1'b0;
        repeat (2) begin @(posedge clk_sys); #1; end
        for (int i = 0; i < 512; i++) begin
          sd_buff_addr = 9'(i);
          if (wr == 0) begin
            sd_buff_dout = img_byte(lba, i);
            sd_buff_wr   = 1'b1;
          end
          @(posedge clk_sys); #1;
          if (reset) begin aborted = 1'b1; break; end
          if (wr != 0) begin
            sbuf[i] = sd_buff_din;
            if (sd_buff_din !== ref_trk[(lba % 13) * 512 + i]) din_bad++;
          end
        end
        sd_buff_wr = 1'b0;
        if (!aborted) begin @(posedge clk_sys); #1; end
        sd_ack = 1'b0;
        if (!aborted && wr != 0)
          for (int i = 0; i < 512; i++) img_wr[lba * 512 + i] = sbuf[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic run_wait(input string tag);
    int n;
    n = 0;
    while (!busy && n < 50) begin tick(1); n++; end
    check({tag, " busy_rise"}, busy, 1);
    n = 0;
    while (busy && n < 20000) begin tick(1); n++; end
    check({tag, " busy_fall"}, busy, 0);
    check({tag, " cpu_wait_end"}, cpu_wait, 0);
  endtask

  task automatic check_ops(input string tag, input int wbase, input int nwr,
                           input int rbase, input int nrd);
    int exp [$];
    int bad;
    for (int i = 0; i < nwr; i++) exp.push_back(65536 + wbase + i);
    for (int i = 0; i < nrd; i++) exp.push_back(rbase + i);
    check({tag, " op_count"}, obs.size(), exp.size());
    bad = 0;
    for (int i = 0; i < exp.size() && i < obs.size(); i++) if (obs[i] != exp[i]) bad++;
    check({tag, " op_sequence"}, bad, 0);
  endtask

  task automatic check_ram(input string tag, input int t);
    int bad;
    bad = 0;
    for (int j = 0; j < 6656; j++) begin
      ref_trk[j] = img_byte(13 * t + j / 512, j % 512);
      if (mem[j] !== ref_trk[j]) bad++;
    end
    check({tag, " ram_contents"}, bad, 0);
  endtask

  task automatic poke_and_dirty(input int n);
    for (int k = 0; k < n; k++) begin
      poke_addr = 13'($urandom_range(0, 6655));
      poke_data = 8'($urandom);
      poke_en = 1'b1;
      tick(1);
      poke_en = 1'b0;
      ref_trk[poke_addr] = poke_data;
    end
    track_dirty_set = 1'b1;
    tick(1);
    track_dirty_set = 1'b0;
  endtask

  initial begin : main
    int we0;
    int n;
    seed = int'($urandom_range(0, 255));
    reset = 1'b1; track = 6'd3; track_dirty_set = 1'b0; img_mounted = 1'b0;
    img_size = 64'd0; img_readonly = 1'b0;
    for (int j = 0; j < 8192; j++) mem[j] = 8'h00;
    for (int j = 0; j < 6656; j++) ref_trk[j] = 8'h00;
    tick(3);
    check("reset sd_lba", sd_lba, 0);
    check("reset busy", busy, 0);
    check("reset cpu_wait", cpu_wait, 0);
    check("reset sd_rd_wr", {sd_rd, sd_wr}, 2'b00);
    reset = 1'b0;

    // No image: track change is recorded, nothing moves.
    tick(20);
    check("noimg busy", busy, 0);
    check("noimg cpu_wait", cpu_wait, 0);
    check("noimg ops", obs.size(), 0);

    // Initial load of track 0.
    obs.delete(); we0 = we_cnt;
    img_size = 64'd232960; track = 6'd0;
    run_wait("load0");
    check_ops("load0", 0, 0, 0, 13);
    check("load0 ram_we", we_cnt - we0, 13 * 512);
    check_ram("load0", 0);

    // Clean track change 0 -> 5.
    obs.delete(); we0 = we_cnt;
    track = 6'd5;
    run_wait("clean5");
    check_ops("clean5", 0, 0, 65, 13);
    check("clean5 ram_we", we_cnt - we0, 13 * 512);
    check_ram("clean5", 5);

    // Dirty track change 5 -> 6: write back 65..77, then load 78..90.
    poke_and_dirty(4);
    obs.delete(); din_bad = 0;
    track = 6'd6;
    run_wait("dirty6");
    check_ops("dirty6", 65, 13, 78, 13);
    check("dirty6 wb_data", din_bad, 0);
    check_ram("dirty6", 6);

    // Read-only image: dirty data is never written back.
    img_readonly = 1'b1;
    poke_and_dirty(3);
    obs.delete();
    track = 6'd7;
    run_wait("ro7");
    check_ops("ro7", 0, 0, 91, 13);
    check_ram("ro7", 7);
    img_readonly = 1'b0;

    // Mount while dirty: pending write-back discarded, new image read.
    poke_and_dirty(2);
    obs.delete();
    img_mounted = 1'b1; track = 6'd8;
    gen++; img_wr.delete();
    tick(1);
    img_mounted = 1'b0;
    run_wait("mount8");
    check_ops("mount8", 0, 0, 104, 13);
    check_ram("mount8", 8);

    // Reset in the middle of write-back sector 4.
    poke_and_dirty(3);
    obs.delete(); din_bad = 0;
    track = 6'd6;
    n = 0;
    while (!(sd_ack && sd_wr && sd_lba == 32'd108) && n < 20000) begin tick(1); n++; end
    check("wbreset reached_sec4", sd_lba, 108);
    tick(100);
    reset = 1'b1;
    #1;
    check("wbreset sd_wr", sd_wr, 0);
    check("wbreset cpu_wait", cpu_wait, 0);
    check("wbreset busy", busy, 0);
    tick(4);
    check_ops("wbreset", 104, 5, 0, 0);
    check("wbreset wb_data", din_bad, 0);
    obs.delete();
    reset = 1'b0;
    run_wait("reload6");
    check_ops("reload6", 0, 0, 78, 13);
    check_ram("reload6", 6);

    check("cpu_wait during acks", cw_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
